// File: rtl/dco_cfg_bank.sv
// dco_cfg_bank: per-channel DCO configuration register bank.
//
// Each channel holds bus-writable shadow codes (cc, fc, div, freq) and a
// separate active set that drives the DCO. Shadow values reach the active set
// only through a commit sequence: request the clock gate, wait for the gate
// acknowledge, apply for one cycle, hold the gate for SETTLE_CYCLES, then
// release the gate and wait for the acknowledge to drop.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   cc_sel_o      active coarse codes, channel i at [i*CC_W +: CC_W]
//   fc_sel_o      active fine codes
//   div_sel_o     active divider selects
//   freq_sel_o    active band selects
//   gate_req_o    per-channel clock-gate request
//   gate_ack_i    per-channel gate acknowledge (synchronous to clk)
//   busy_o        per-channel commit in progress
//   req_i/rsp_o   register bus; response is combinational, ready always 1
//
// Optional build macro: DCO_CFG_TIMEOUT_EN adds a 1024-cycle handshake
// timeout in the REQ and REL states, reported in STATUS bit2 (W1C).

typedef struct packed {
  logic        valid;
  logic        write;
  logic [11:0] addr;
  logic [63:0] wdata;
} dco_cfg_req_t;

typedef struct packed {
  logic        ready;
  logic [63:0] rdata;
  logic        error;
} dco_cfg_rsp_t;

module dco_cfg_bank #(
  parameter int unsigned NUM_DCO       = 2,
  parameter int unsigned CC_W          = 6,
  parameter int unsigned FC_W          = 6,
  parameter int unsigned DIV_W         = 3,
  parameter int unsigned FREQ_W        = 2,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter type         reg_req_t     = dco_cfg_req_t,
  parameter type         reg_rsp_t     = dco_cfg_rsp_t
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [NUM_DCO*CC_W-1:0]     cc_sel_o,
  output logic [NUM_DCO*FC_W-1:0]     fc_sel_o,
  output logic [NUM_DCO*DIV_W-1:0]    div_sel_o,
  output logic [NUM_DCO*FREQ_W-1:0]   freq_sel_o,
  output logic [NUM_DCO-1:0]          gate_req_o,
  input  logic [NUM_DCO-1:0]          gate_ack_i,
  output logic [NUM_DCO-1:0]          busy_o,
  input  reg_req_t                    req_i,
  output reg_rsp_t                    rsp_o
);

  localparam logic [5:0] OFF_CC     = 6'h00;
  localparam logic [5:0] OFF_FC     = 6'h08;
  localparam logic [5:0] OFF_DIV    = 6'h10;
  localparam logic [5:0] OFF_FREQ   = 6'h18;
  localparam logic [5:0] OFF_COMMIT = 6'h20;
  localparam logic [5:0] OFF_STATUS = 6'h28;
  localparam logic [5:0] OFF_ACT    = 6'h30;

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(1'b1) << (DIV_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_APPLY  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_REL    = 3'd4
  } state_e;

  state_e              state_r     [NUM_DCO];
  state_e              state_nxt_s [NUM_DCO];
  logic [CC_W-1:0]     cc_sh_r     [NUM_DCO];
  logic [FC_W-1:0]     fc_sh_r     [NUM_DCO];
  logic [DIV_W-1:0]    div_sh_r    [NUM_DCO];
  logic [FREQ_W-1:0]   freq_sh_r   [NUM_DCO];
  logic [CC_W-1:0]     cc_act_r    [NUM_DCO];
  logic [FC_W-1:0]     fc_act_r    [NUM_DCO];
  logic [DIV_W-1:0]    div_act_r   [NUM_DCO];
  logic [FREQ_W-1:0]   freq_act_r  [NUM_DCO];
  logic [CNT_W-1:0]    settle_cnt_r[NUM_DCO];
  logic [7:0]          commit_cnt_r[NUM_DCO];
  logic [63:0]         status_s    [NUM_DCO];
  logic [63:0]         active_s    [NUM_DCO];
  logic [63:0]         ch_rd_s     [NUM_DCO];
  logic [NUM_DCO-1:0]  gate_req_r;
  logic [NUM_DCO-1:0]  busy_s, dirty_s, to_flag_s, tmo_s;
  logic [NUM_DCO-1:0]  sel_s, ch_err_s, wr_ok_s;
  logic [NUM_DCO-1:0]  wr_cc_s, wr_fc_s, wr_div_s, wr_freq_s, commit_s, clr_to_s;
  logic [63:0]         rdata_s;
  logic                error_s;
  logic [5:0]          off_s;

  assign off_s      = req_i.addr[5:0];
  assign gate_req_o = gate_req_r;
  assign busy_o     = busy_s;

  for (genvar g = 0; g < NUM_DCO; g++) begin : g_ch
    assign cc_sel_o[g*CC_W +: CC_W]       = cc_act_r[g];
    assign fc_sel_o[g*FC_W +: FC_W]       = fc_act_r[g];
    assign div_sel_o[g*DIV_W +: DIV_W]    = div_act_r[g];
    assign freq_sel_o[g*FREQ_W +: FREQ_W] = freq_act_r[g];
    assign busy_s[g]   = (state_r[g] != ST_IDLE);
    assign dirty_s[g]  = (cc_sh_r[g] != cc_act_r[g]) || (fc_sh_r[g] != fc_act_r[g]) ||
                         (div_sh_r[g] != div_act_r[g]) || (freq_sh_r[g] != freq_act_r[g]);
    assign status_s[g] = 64'({commit_cnt_r[g], 5'd0, to_flag_s[g], dirty_s[g], busy_s[g]});
    assign active_s[g] = 64'({freq_act_r[g], div_act_r[g], fc_act_r[g], cc_act_r[g]});
  end

`ifdef DCO_CFG_TIMEOUT_EN
  logic [9:0]         tmo_tmr_r [NUM_DCO];
  logic [NUM_DCO-1:0] timeout_r;
  logic [NUM_DCO-1:0] wait_s;
  logic               unused_s;

  // Timer runs only while the handshake waits for its expected ack level.
  always_comb begin
    for (int i = 0; i < NUM_DCO; i++) begin
      wait_s[i] = ((state_r[i] == ST_REQ) && !gate_ack_i[i]) ||
                  ((state_r[i] == ST_REL) &&  gate_ack_i[i]);
      tmo_s[i]  = wait_s[i] && (tmo_tmr_r[i] == 10'h3FF);
    end
  end

  // Handshake timer and sticky timeout flag (set wins over W1C).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DCO; i++) tmo_tmr_r[i] <= 10'd0;
      timeout_r <= '0;
    end else begin
      for (int i = 0; i < NUM_DCO; i++) begin
        tmo_tmr_r[i] <= wait_s[i] ? tmo_tmr_r[i] + 10'd1 : 10'd0;
        if (tmo_s[i])         timeout_r[i] <= 1'b1;
        else if (clr_to_s[i]) timeout_r[i] <= 1'b0;
      end
    end
  end

  assign to_flag_s = timeout_r;
  assign unused_s  = ^req_i.wdata;
`else
  logic unused_s;
  assign tmo_s     = '0;
  assign to_flag_s = '0;
  // The W1C strobe has nothing to clear without the timeout feature.
  assign unused_s  = ^{req_i.wdata, clr_to_s};
`endif

  // Bus decode: per-channel read mux, error detection and write strobes.
  always_comb begin
    rdata_s   = 64'd0;
    sel_s     = '0;
    ch_err_s  = '0;
    wr_ok_s   = '0;
    wr_cc_s   = '0;
    wr_fc_s   = '0;
    wr_div_s  = '0;
    wr_freq_s = '0;
    commit_s  = '0;
    clr_to_s  = '0;
    for (int i = 0; i < NUM_DCO; i++) begin
      ch_rd_s[i] = 64'd0;
      sel_s[i]   = req_i.valid && (req_i.addr[11:6] == 6'(i));
      if (sel_s[i] && !req_i.write) begin
        case (off_s)
          OFF_CC:     ch_rd_s[i] = 64'(cc_sh_r[i]);
          OFF_FC:     ch_rd_s[i] = 64'(fc_sh_r[i]);
          OFF_DIV:    ch_rd_s[i] = 64'(div_sh_r[i]);
          OFF_FREQ:   ch_rd_s[i] = 64'(freq_sh_r[i]);
          OFF_COMMIT: ch_rd_s[i] = 64'd0;
          OFF_STATUS: ch_rd_s[i] = status_s[i];
          OFF_ACT:    ch_rd_s[i] = active_s[i];
          default:    ch_err_s[i] = 1'b1;
        endcase
      end else if (sel_s[i]) begin
        // Shadow and commit writes are locked out while a commit runs.
        case (off_s)
          OFF_CC, OFF_FC, OFF_DIV, OFF_FREQ, OFF_COMMIT: ch_err_s[i] = busy_s[i];
          OFF_STATUS: ch_err_s[i] = 1'b0;
          default:    ch_err_s[i] = 1'b1;
        endcase
      end else begin
        ch_err_s[i] = 1'b0;
      end
      wr_ok_s[i]   = sel_s[i] && req_i.write && !ch_err_s[i];
      wr_cc_s[i]   = wr_ok_s[i] && (off_s == OFF_CC);
      wr_fc_s[i]   = wr_ok_s[i] && (off_s == OFF_FC);
      wr_div_s[i]  = wr_ok_s[i] && (off_s == OFF_DIV);
      wr_freq_s[i] = wr_ok_s[i] && (off_s == OFF_FREQ);
      commit_s[i]  = wr_ok_s[i] && (off_s == OFF_COMMIT) && req_i.wdata[0];
      clr_to_s[i]  = wr_ok_s[i] && (off_s == OFF_STATUS) && req_i.wdata[2];
      rdata_s      = rdata_s | ch_rd_s[i];
    end
    error_s = (|ch_err_s) || (req_i.valid && (sel_s == '0));
  end

  // Combinational bus response.
  always_comb begin
    rsp_o       = '0;
    rsp_o.ready = 1'b1;
    rsp_o.rdata = rdata_s;
    rsp_o.error = error_s;
  end

  // Commit FSM next-state, one independent machine per channel.
  always_comb begin
    for (int i = 0; i < NUM_DCO; i++) begin
      state_nxt_s[i] = state_r[i];
      case (state_r[i])
        ST_IDLE:   state_nxt_s[i] = commit_s[i] ? ST_REQ : ST_IDLE;
        ST_REQ:    state_nxt_s[i] = gate_ack_i[i] ? ST_APPLY : (tmo_s[i] ? ST_IDLE : ST_REQ);
        ST_APPLY:  state_nxt_s[i] = ST_SETTLE;
        ST_SETTLE: state_nxt_s[i] = (settle_cnt_r[i] == '0) ? ST_REL : ST_SETTLE;
        ST_REL:    state_nxt_s[i] = (!gate_ack_i[i] || tmo_s[i]) ? ST_IDLE : ST_REL;
        default:   state_nxt_s[i] = ST_IDLE;
      endcase
    end
  end

  // State, shadow/active registers, settle and commit counters, gate request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DCO; i++) begin
        state_r[i]      <= ST_IDLE;
        cc_sh_r[i]      <= {CC_W{1'b1}};
        fc_sh_r[i]      <= {FC_W{1'b1}};
        div_sh_r[i]     <= DIV_RST;
        freq_sh_r[i]    <= {FREQ_W{1'b1}};
        cc_act_r[i]     <= {CC_W{1'b1}};
        fc_act_r[i]     <= {FC_W{1'b1}};
        div_act_r[i]    <= DIV_RST;
        freq_act_r[i]   <= {FREQ_W{1'b1}};
        settle_cnt_r[i] <= '0;
        commit_cnt_r[i] <= 8'd0;
      end
      gate_req_r <= '0;
    end else begin
      for (int i = 0; i < NUM_DCO; i++) begin
        state_r[i] <= state_nxt_s[i];
        // Registered request: high for REQ/APPLY/SETTLE, low from REL onwards.
        gate_req_r[i] <= (state_nxt_s[i] == ST_REQ) || (state_nxt_s[i] == ST_APPLY) ||
                         (state_nxt_s[i] == ST_SETTLE);
        if (wr_cc_s[i])   cc_sh_r[i]   <= req_i.wdata[CC_W-1:0];
        if (wr_fc_s[i])   fc_sh_r[i]   <= req_i.wdata[FC_W-1:0];
        if (wr_div_s[i])  div_sh_r[i]  <= req_i.wdata[DIV_W-1:0];
        if (wr_freq_s[i]) freq_sh_r[i] <= req_i.wdata[FREQ_W-1:0];
        if (state_r[i] == ST_APPLY) begin
          cc_act_r[i]     <= cc_sh_r[i];
          fc_act_r[i]     <= fc_sh_r[i];
          div_act_r[i]    <= div_sh_r[i];
          freq_act_r[i]   <= freq_sh_r[i];
          commit_cnt_r[i] <= commit_cnt_r[i] + 8'd1;
          settle_cnt_r[i] <= SETTLE_LOAD;
        end else if ((state_r[i] == ST_SETTLE) && (settle_cnt_r[i] != '0)) begin
          settle_cnt_r[i] <= settle_cnt_r[i] - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule
